// File: rtl/aes_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_arbiter_if
// Purpose  : Request/response and core-side bundle for the shared AES arbiter.
// Revision : 1.0
// ============================================================================
interface aes_arbiter_if #(
  parameter int KEY_W  = 128,
  parameter int DATA_W = 128
);
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [2*KEY_W-1:0]  req_key;
  logic [2*DATA_W-1:0] req_data;
  logic [1:0]          req_dec;
  logic [1:0]          rsp_valid;
  logic [1:0]          rsp_ready;
  logic [DATA_W-1:0]   rsp_data;
  logic [KEY_W-1:0]    core_key;
  logic [DATA_W-1:0]   core_data;
  logic [1:0]          core_func;
  logic                core_enable;
  logic                core_ready;
  logic [DATA_W-1:0]   core_result;

  // Arbiter side.
  modport slave (
    input  req_valid, req_key, req_data, req_dec, rsp_ready, core_ready, core_result,
    output req_ready, rsp_valid, rsp_data, core_key, core_data, core_func, core_enable
  );

  // Requesters plus AES core side.
  modport master (
    output req_valid, req_key, req_data, req_dec, rsp_ready, core_ready, core_result,
    input  req_ready, rsp_valid, rsp_data, core_key, core_data, core_func, core_enable
  );
endinterface
`default_nettype wire

// File: rtl/aes_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : aes_arbiter
// Purpose  : Round-robin sharing of one AES core between two requesters,
//            issuing key expansion ahead of each operation when required.
//            Define AES_ARB_KEYCACHE_EN to skip expansion of an already loaded key.
// Revision : 1.0
// ============================================================================
module aes_arbiter #(
  parameter int KEY_W  = 128,
  parameter int DATA_W = 128
) (
  input  logic         clk,
  input  logic         rst,
  aes_arbiter_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    KEY_GO   = 3'd1,
    KEY_WAIT = 3'd2,
    OP_GO    = 3'd3,
    OP_WAIT  = 3'd4,
    RESP     = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [KEY_W-1:0]  r_key;
  logic [DATA_W-1:0] r_data;
  logic              r_dec;
  logic              r_grant;
  logic              r_last_grant;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_core_armed;

  logic              w_grant;
  logic              w_accept;
  logic              w_core_done;
  logic              w_need_key;
  logic [KEY_W-1:0]  w_sel_key;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_sel_dec;

  assign w_grant    = (&bus.req_valid) ? ~r_last_grant : bus.req_valid[1];
  assign w_accept   = (r_state == IDLE) && (|bus.req_valid);
  assign w_sel_key  = w_grant ? bus.req_key[2*KEY_W-1:KEY_W]    : bus.req_key[KEY_W-1:0];
  assign w_sel_data = w_grant ? bus.req_data[2*DATA_W-1:DATA_W] : bus.req_data[DATA_W-1:0];
  assign w_sel_dec  = w_grant ? bus.req_dec[1] : bus.req_dec[0];

  // A completion left over from before reset is dropped until we start the core ourselves.
  assign w_core_done = bus.core_ready && r_core_armed;

`ifdef AES_ARB_KEYCACHE_EN
  logic             r_key_loaded;
  logic [KEY_W-1:0] r_loaded_key;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_loaded <= 1'b0;
      r_loaded_key <= '0;
    end else if (r_state == KEY_GO) begin
      r_key_loaded <= 1'b0;
    end else if ((r_state == KEY_WAIT) && w_core_done) begin
      r_key_loaded <= 1'b1;
      r_loaded_key <= r_key;
    end
  end

  assign w_need_key = !r_key_loaded || (w_sel_key != r_loaded_key);
`else
  assign w_need_key = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_key        <= '0;
      r_data       <= '0;
      r_dec        <= 1'b0;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_rsp_data   <= '0;
      r_core_armed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_key        <= w_sel_key;
        r_data       <= w_sel_data;
        r_dec        <= w_sel_dec;
        r_grant      <= w_grant;
        r_last_grant <= w_grant;
      end
      if (bus.core_enable) begin
        r_core_armed <= 1'b1;
      end
      if ((r_state == OP_WAIT) && w_core_done) begin
        r_rsp_data <= bus.core_result;
      end
    end
  end

  assign bus.rsp_data = r_rsp_data;

  always_comb begin
    w_state_nxt     = r_state;
    bus.req_ready   = 2'b00;
    bus.rsp_valid   = 2'b00;
    bus.core_key    = '0;
    bus.core_data   = '0;
    bus.core_func   = 2'd0;
    bus.core_enable = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          // The strobe is combinational, so hold it low while reset is asserted.
          bus.req_ready = rst ? 2'b00 : (w_grant ? 2'b10 : 2'b01);
          w_state_nxt   = w_need_key ? KEY_GO : OP_GO;
        end
      end
      KEY_GO: begin
        bus.core_key    = r_key;
        bus.core_func   = 2'd1;
        bus.core_enable = 1'b1;
        w_state_nxt     = KEY_WAIT;
      end
      KEY_WAIT: begin
        bus.core_key  = r_key;
        bus.core_func = 2'd1;
        if (w_core_done) begin
          w_state_nxt = OP_GO;
        end
      end
      OP_GO: begin
        bus.core_data   = r_data;
        bus.core_func   = r_dec ? 2'd3 : 2'd2;
        bus.core_enable = 1'b1;
        w_state_nxt     = OP_WAIT;
      end
      OP_WAIT: begin
        bus.core_data = r_data;
        bus.core_func = r_dec ? 2'd3 : 2'd2;
        if (w_core_done) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid = r_grant ? 2'b10 : 2'b01;
        if (bus.rsp_ready[r_grant]) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end
endmodule
`default_nettype wire

// File: tb/tb_aes_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_arbiter
// Purpose  : Directed scoreboard bench for aes_arbiter with a behavioural AES core.
// Revision : 1.0
// ============================================================================
module tb_aes_arbiter;
  localparam int KEY_W   = 128;
  localparam int DATA_W  = 128;
  localparam int KEY_LAT = 4;
  localparam int OP_LAT  = 6;
  localparam int BUDGET  = 500;
`ifdef AES_ARB_KEYCACHE_EN
  localparam int EXP_REUSE_KEYS = 0;
`else
  localparam int EXP_REUSE_KEYS = 1;
`endif

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P3 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C3 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_arbiter_if #(.KEY_W(KEY_W), .DATA_W(DATA_W)) bus ();
  aes_arbiter #(.KEY_W(KEY_W), .DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int checks = 0;
  int failures = 0;
  int key_pulses = 0;
  int op_pulses = 0;
  logic [DATA_W-1:0] sb0[$];
  logic [DATA_W-1:0] sb1[$];

  // Reference AES built from published FIPS-197 / SP800-38A vectors.
  function automatic logic [DATA_W-1:0] aes_ref(input logic [KEY_W-1:0] k,
                                                input logic [DATA_W-1:0] d, input logic dec);
    if (k == K1 && !dec && d == P1) return C1;
    if (k == K1 &&  dec && d == C1) return P1;
    if (k == K2 && !dec && d == P2) return C2;
    if (k == K2 &&  dec && d == C2) return P2;
    if (k == K2 && !dec && d == P3) return C3;
    if (k == K2 &&  dec && d == C3) return P3;
    return d ^ k ^ {{(DATA_W-1){1'b0}}, dec};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural core: keeps its own expanded key, so a missing key job corrupts results.
  initial begin : core_model
    logic             busy;
    int               cnt;
    logic [1:0]       func;
    logic [KEY_W-1:0] pkey;
    logic [KEY_W-1:0] mkey;
    logic [DATA_W-1:0] pdata;
    busy = 1'b0; cnt = 0; func = 2'd0; pkey = '0; mkey = '0; pdata = '0;
    bus.core_ready = 1'b0;
    bus.core_result = '0;
    forever begin
      @(negedge clk);
      #2;
      bus.core_ready = 1'b0;
      if (busy) begin
        cnt--;
        if (cnt == 0) begin
          busy = 1'b0;
          bus.core_ready = 1'b1;
          if (func == 2'd1) begin
            mkey = pkey;
            bus.core_result = '0;
          end else begin
            bus.core_result = aes_ref(mkey, pdata, func == 2'd3);
          end
        end
      end
      if (bus.core_enable) begin
        busy  = 1'b1;
        func  = bus.core_func;
        pkey  = bus.core_key;
        pdata = bus.core_data;
        cnt   = (func == 2'd1) ? KEY_LAT : OP_LAT;
        if (func == 2'd1) key_pulses++;
        else op_pulses++;
      end
    end
  end

  task automatic take(input int n);
    int sz;
    logic [DATA_W-1:0] e;
    sz = (n == 0) ? sb0.size() : sb1.size();
    checks++;
    assert (sz > 0) else begin
      failures++;
      $error("FAIL rsp_unexpected_req%0d observed=response expected=none", n);
    end
    if (sz > 0) begin
      if (n == 0) e = sb0.pop_front();
      else e = sb1.pop_front();
      chk($sformatf("rsp_data_req%0d", n), bus.rsp_data, e);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (bus.rsp_valid != 2'b00) chk("rsp_valid_onehot", $onehot(bus.rsp_valid), 1);
    if (bus.rsp_valid[0] && bus.rsp_ready[0]) take(0);
    if (bus.rsp_valid[1] && bus.rsp_ready[1]) take(1);
  end

  task automatic set_req(input int n, input logic [KEY_W-1:0] k,
                         input logic [DATA_W-1:0] d, input logic dec);
    if (n == 0) begin
      bus.req_key[KEY_W-1:0]   = k;
      bus.req_data[DATA_W-1:0] = d;
      bus.req_dec[0]           = dec;
      bus.req_valid[0]         = 1'b1;
      sb0.push_back(aes_ref(k, d, dec));
    end else begin
      bus.req_key[2*KEY_W-1:KEY_W]    = k;
      bus.req_data[2*DATA_W-1:DATA_W] = d;
      bus.req_dec[1]                  = dec;
      bus.req_valid[1]                = 1'b1;
      sb1.push_back(aes_ref(k, d, dec));
    end
  endtask

  task automatic wait_accept(input int n);
    int cyc;
    cyc = 0;
    #1;
    while (bus.req_ready[n] !== 1'b1 && cyc < BUDGET) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk($sformatf("req_ready_%0d", n), bus.req_ready, (n == 0) ? 2'b01 : 2'b10);
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int n, input logic [KEY_W-1:0] k,
                       input logic [DATA_W-1:0] d, input logic dec);
    @(negedge clk);
    set_req(n, k, d, dec);
    wait_accept(n);
    bus.req_valid[n] = 1'b0;
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while ((sb0.size() + sb1.size()) != 0 && cyc < 4 * BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    chk("drain_pending", sb0.size() + sb1.size(), 0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_core_enable"}, bus.core_enable, 0);
    chk({tag, "_core_func"}, bus.core_func, 0);
    chk({tag, "_core_key"}, bus.core_key, 0);
    chk({tag, "_core_data"}, bus.core_data, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int kp, op, cyc, i0, i1, g;
    int glog[$];
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] jd0[3];
    logic [DATA_W-1:0] jd1[3];
    logic jdec0[3];
    logic jdec1[3];
    jd0[0] = P1; jd0[1] = C1; jd0[2] = P1; jdec0[0] = 1'b0; jdec0[1] = 1'b1; jdec0[2] = 1'b0;
    jd1[0] = P2; jd1[1] = P3; jd1[2] = C2; jdec1[0] = 1'b0; jdec1[1] = 1'b0; jdec1[2] = 1'b1;

    bus.req_valid = 2'b00; bus.req_key = '0; bus.req_data = '0; bus.req_dec = 2'b00;
    bus.rsp_ready = 2'b11;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    bus.req_valid = 2'b01;
    #1;
    chk_idle_outputs("reset");
    chk("reset_rsp_data", bus.rsp_data, 0);
    bus.req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;

    // Encrypt on a cold core: one key job, then one operation.
    kp = key_pulses; op = op_pulses;
    issue(0, K1, P1, 1'b0);
    drain();
    chk("enc_key_jobs", key_pulses - kp, 1);
    chk("enc_op_jobs", op_pulses - op, 1);

    // Decrypt under the same key.
    kp = key_pulses; op = op_pulses;
    issue(0, K1, C1, 1'b1);
    drain();
    chk("dec_key_jobs", key_pulses - kp, EXP_REUSE_KEYS);
    chk("dec_op_jobs", op_pulses - op, 1);

    // Fresh reset, then both requesters saturated with alternating keys.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    kp = key_pulses; op = op_pulses;
    @(negedge clk);
    set_req(0, K1, jd0[0], jdec0[0]);
    set_req(1, K2, jd1[0], jdec1[0]);
    i0 = 0; i1 = 0; cyc = 0;
    while (glog.size() < 6 && cyc < 8 * BUDGET) begin
      #1;
      if (bus.req_ready != 2'b00) begin
        chk("alt_req_ready_onehot", $onehot(bus.req_ready), 1);
        g = int'(bus.req_ready[1]);
        glog.push_back(g);
        @(posedge clk);
        #1;
        if (g == 0) begin
          i0++;
          if (i0 < 3) set_req(0, K1, jd0[i0], jdec0[i0]);
          else bus.req_valid[0] = 1'b0;
        end else begin
          i1++;
          if (i1 < 3) set_req(1, K2, jd1[i1], jdec1[i1]);
          else bus.req_valid[1] = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.req_valid = 2'b00;
    chk("alt_grant_count", glog.size(), 6);
    for (int i = 0; i < glog.size(); i++) chk($sformatf("alt_grant_%0d", i), glog[i], i % 2);
    drain();
    chk("alt_key_jobs", key_pulses - kp, 6);
    chk("alt_op_jobs", op_pulses - op, 6);

    // Response back-pressure on requester 1 while requester 0 waits.
    bus.rsp_ready = 2'b01;
    issue(1, K2, P3, 1'b0);
    cyc = 0;
    while (bus.rsp_valid[1] !== 1'b1 && cyc < BUDGET) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("stall_rsp_valid", bus.rsp_valid, 2'b10);
    hold = bus.rsp_data;
    set_req(0, K1, P1, 1'b0);
    repeat (10) begin
      @(negedge clk);
      #1;
      chk("stall_valid_held", bus.rsp_valid, 2'b10);
      chk("stall_data_held", bus.rsp_data, hold);
      chk("stall_no_grant", bus.req_ready, 2'b00);
    end
    bus.rsp_ready[1] = 1'b1;
    @(negedge clk);
    #1;
    chk("release_rsp_valid", bus.rsp_valid, 2'b00);
    chk("release_next_grant", bus.req_ready, 2'b01);
    wait_accept(0);
    bus.req_valid[0] = 1'b0;
    drain();

    // Reset while the core is expanding a key; its late completion must be ignored.
    issue(0, K2, P2, 1'b0);
    cyc = 0;
    while (!(bus.core_func == 2'd1 && !bus.core_enable) && cyc < BUDGET) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("abort_in_key_wait", bus.core_func, 1);
    rst = 1'b1;
    #1;
    chk_idle_outputs("abort");
    chk("abort_rsp_data", bus.rsp_data, 0);
    void'(sb0.pop_back());
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk_idle_outputs("stray");
    kp = key_pulses;
    issue(0, K2, P2, 1'b0);
    drain();
    chk("post_reset_key_jobs", key_pulses - kp, 1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/aes_arbiter.md
Name: aes_arbiter

Overview:
- Two-requester controller that shares one AES core (the iterative or pipelined variant) between two clients.
- Grants requests round-robin and tracks which key is currently expanded in the core.
- Issues a key-expansion job before an encrypt/decrypt whenever the granted key differs from the loaded key.
- Returns each result to its requester through a valid/ready response port.

Parameters:
- KEY_W, 128, key width in bits; equals 32*Nk of the core.
- DATA_W, 128, block width in bits; equals 32*Nb of the core.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-requester request valid; bit n belongs to requester n.
- req_ready  out  2  per-requester accept strobe; one-hot, one cycle.
- req_key  in  2*KEY_W  per-requester key; slice n is key of requester n.
- req_data  in  2*DATA_W  per-requester plaintext or ciphertext.
- req_dec  in  2  per-requester operation select: 1 = decrypt, 0 = encrypt.
- rsp_valid  out  2  per-requester response valid.
- rsp_ready  in  2  per-requester response accept.
- rsp_data  out  DATA_W  response block; shared by both requesters, qualified by rsp_valid.
- core_key  out  KEY_W  key presented to the core.
- core_data  out  DATA_W  block presented to the core.
- core_func  out  2  core function: 1 = key expansion, 2 = encrypt, 3 = decrypt.
- core_enable  out  1  single-cycle start pulse to the core.
- core_ready  in  1  core completion strobe.
- core_result  in  DATA_W  core result; valid with core_ready.

Behaviour:
- Reset (async, rst=1):
  - all outputs 0, state IDLE.
  - key_loaded=0, last_grant=1, so requester 0 wins first.
- State machine: IDLE -> KEY_GO -> KEY_WAIT -> OP_GO -> OP_WAIT -> RESP -> IDLE.
- IDLE:
  - If any req_valid is set, grant one requester: if both are set, grant ~last_grant; otherwise grant the single requester.
  - Assert req_ready[g] for exactly one cycle.
  - Capture key, data and dec into internal registers; set last_grant=g.
  - Next state: KEY_GO if key_loaded=0 or the captured key differs from the loaded key; otherwise OP_GO.
- KEY_GO (1 cycle):
  - core_key = captured key, core_func=1, core_enable=1.
  - Clear key_loaded.
  - Next state: KEY_WAIT.
- KEY_WAIT:
  - core_enable=0; hold core_key/core_func.
  - On core_ready: loaded key = captured key, key_loaded=1, next state OP_GO.
- OP_GO (1 cycle):
  - core_data = captured data, core_key=0, core_func = dec ? 3 : 2, core_enable=1.
  - Next state: OP_WAIT.
- OP_WAIT:
  - On core_ready: latch core_result into rsp_data; next state RESP.
- RESP:
  - rsp_valid[g]=1; hold rsp_data.
  - On rsp_ready[g]: clear rsp_valid and go to IDLE.
  - Earliest next grant is the cycle after.
- Handshake rules:
  - core_ready is ignored in IDLE, KEY_GO, OP_GO and RESP.
  - Requests are not accepted outside IDLE; req_valid is held by the requester until req_ready.
  - Inputs are sampled only on the req_ready cycle; later changes on the request port have no effect on the job in flight.
  - rsp_valid is never asserted for the non-granted requester.
- Latency: accept -> rsp_valid = 2 + core key time (if a key load is needed) + 2 + core operation time.
- Key compare is a full KEY_W equality on the registered key.
- Reset mid-operation: the core may still be running. After reset the arbiter drops any core_ready that arrives before the first core_enable it issues.

Optional Feature:
- AES_ARB_KEYCACHE_EN
- Defined: key-cache behaviour as above. Key expansion is skipped when the key matches and key_loaded=1.
- Undefined:
  - Every grant goes IDLE -> KEY_GO, so key expansion runs before every operation.
  - The key compare logic is removed.
  - Outputs and handshakes are otherwise identical.

Test Plan:
- Requester 0 encrypts key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff -> one func=1 job, then one func=2 job; rsp_valid[0] with rsp_data 69c4e0d86a7b0430d8cdb78070b4c55a.
- Same key, req_dec=1, data 69c4e0d86a7b0430d8cdb78070b4c55a -> expected response is 00112233445566778899aabbccddeeff.
  - With AES_ARB_KEYCACHE_EN: no func=1 pulse.
  - Without the macro: one func=1 pulse before the operation.
- Both req_valid held high continuously for 6 jobs -> grants alternate 0,1,0,1,0,1; each req_ready is a one-cycle one-hot strobe.
- Requester 0 and requester 1 use different keys, interleaved -> a func=1 job precedes every operation; all results match reference vectors.
- Hold rsp_ready[1]=0 for 10 cycles in RESP -> rsp_valid[1] and rsp_data stay stable and no new grant is made; rsp_ready=1 -> back to IDLE in the next cycle.
- Assert rst during KEY_WAIT -> all outputs 0 immediately.
  - key_loaded=0, so the next job issues key expansion.
  - A stray core_ready arriving after reset is ignored.
